// File: rtl/gf_seq_mult.sv
// gf_seq_mult: iterative unsigned / carry-less multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Define GF_SEQ_MULT_REDUCE_EN to add the poly port and reduction of GF products modulo x^N + poly.
module gf_seq_mult #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    gf_option,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
`ifdef GF_SEQ_MULT_REDUCE_EN
  input  logic [DATA_WIDTH-1:0]   poly,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out
);
  localparam int N  = DATA_WIDTH;
  localparam int K  = BITS_PER_CYCLE;
  localparam int L  = N / K;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED, S_DONE} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_acc, r_a_sh, r_out, w_mul_sum;
  logic [N-1:0]   r_b;
  logic           r_gf;
  logic           w_accept, w_last;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_out;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == CW'(L - 1));

  // One K-bit slice of the multiplier per cycle; r_a_sh already carries the slice's weight.
  always_comb begin
    // NOTE: blocking '=' chains the K partial sums within one cycle; the leading default keeps this latch-free.
    w_mul_sum = r_acc;
    for (int i = 0; i < K; i++) begin
      if (r_b[i]) begin
        if (r_gf) w_mul_sum = w_mul_sum ^ (r_a_sh << i);
        else      w_mul_sum = w_mul_sum + (r_a_sh << i);
      end
    end
  end

`ifdef GF_SEQ_MULT_REDUCE_EN
  localparam int SW = $clog2(2 * N);

  logic [N-1:0]   r_poly;
  logic [2*N-1:0] w_poly_full, w_red_sum;
  logic [SW-1:0]  w_top;

  assign w_poly_full = {{(N-1){1'b0}}, 1'b1, r_poly};

  // Clear K high-order terms per cycle, highest first, since each step can set lower ones.
  always_comb begin
    w_red_sum = r_acc;
    w_top     = '0;
    for (int i = 0; i < K; i++) begin
      w_top = SW'(2 * N - 1 - K * int'(r_cnt) - i);
      if (w_red_sum[w_top]) w_red_sum = w_red_sum ^ (w_poly_full << (w_top - SW'(N)));
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_MUL;
      S_MUL: begin
        if (w_last) begin
`ifdef GF_SEQ_MULT_REDUCE_EN
          w_next = r_gf ? S_RED : S_DONE;
`else
          w_next = S_DONE;
`endif
        end
      end
      S_RED:  if (w_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath is reset too, so out reads 0 after rst and no stale job survives it.
    if (rst) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a_sh <= '0;
      r_b    <= '0;
      r_gf   <= 1'b0;
      r_out  <= '0;
`ifdef GF_SEQ_MULT_REDUCE_EN
      r_poly <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sh <= {{N{1'b0}}, a};
            r_b    <= b;
            r_gf   <= gf_option;
            r_acc  <= '0;
            r_cnt  <= '0;
`ifdef GF_SEQ_MULT_REDUCE_EN
            r_poly <= poly;
`endif
          end
        end
        S_MUL: begin
          r_acc  <= w_mul_sum;
          r_a_sh <= r_a_sh << K;
          r_b    <= r_b >> K;
          r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last && (w_next == S_DONE)) r_out <= w_mul_sum;
        end
`ifdef GF_SEQ_MULT_REDUCE_EN
        S_RED: begin
          r_acc <= w_red_sum;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) r_out <= {{N{1'b0}}, w_red_sum[N-1:0]};
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_seq_mult.sv
// tb_gf_seq_mult: directed and randomized checks of gf_seq_mult (N=8, K=2) against a polynomial-arithmetic model.
// Honours GF_SEQ_MULT_REDUCE_EN so the same bench covers both builds.
module tb_gf_seq_mult;
  localparam int N = 8;
  localparam int K = 2;
  localparam int L = N / K;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, gf_option, out_valid, out_ready;
  logic [N-1:0]   a, b, poly;
  logic [2*N-1:0] out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

`ifdef GF_SEQ_MULT_REDUCE_EN
  localparam int GF_LAT = 2 * L;
`else
  localparam int GF_LAT = L;
`endif

  gf_seq_mult #(.DATA_WIDTH(N), .BITS_PER_CYCLE(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gf_option (gf_option),
    .a         (a),
    .b         (b),
`ifdef GF_SEQ_MULT_REDUCE_EN
    .poly      (poly),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: integer product, or carry-less product optionally reduced by summing x^k mod m.
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic gf, input logic [7:0] p);
    logic [15:0] prod;
    logic [7:0]  r, xk;
    if (!gf) return 16'({8'b0, x} * {8'b0, y});
    prod = '0;
    for (int i = 0; i < 8; i++) if (y[i]) prod = prod ^ ({8'b0, x} << i);
`ifdef GF_SEQ_MULT_REDUCE_EN
    r  = prod[7:0];
    xk = p;
    for (int k = 8; k < 16; k++) begin
      if (prod[k]) r = r ^ xk;
      xk = {xk[6:0], 1'b0} ^ (xk[7] ? p : 8'h00);
    end
    return {8'h00, r};
`else
    xk = p;
    r  = xk;
    return prod;
`endif
  endfunction

  // Presents one job, returns the first result seen and the cycles from acceptance to out_valid.
  task automatic run_job(input logic [7:0] xa, input logic [7:0] xb, input logic gf,
                         output logic [15:0] res, output int lat);
    a = xa; b = xb; gf_option = gf; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    res = out;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [15:0] res, held, exp;
  int          lat, guard, prev_edge, this_edge;
  logic        prev_gf;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; gf_option = 1'b0;
    a = '0; b = '0; poly = 8'h1B;
    tick(); tick();
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out", 32'(out), 32'd0);

    run_job(8'hFF, 8'hFF, 1'b0, res, lat);
    check("int FFxFF", 32'(res), 32'h0000FE01);
    check("int FFxFF latency", 32'(lat), 32'(L));
    check("DONE in_ready", 32'(in_ready), 32'd0);
    release_result();

    run_job(8'hFF, 8'hFF, 1'b1, res, lat);
`ifdef GF_SEQ_MULT_REDUCE_EN
    check("gf FFxFF reduced", 32'(res), 32'(model(8'hFF, 8'hFF, 1'b1, poly)));
`else
    check("gf FFxFF", 32'(res), 32'h00005555);
`endif
    check("gf FFxFF out[15]", 32'(res[15]), 32'd0);
    release_result();

    run_job(8'h57, 8'h83, 1'b1, res, lat);
`ifdef GF_SEQ_MULT_REDUCE_EN
    check("gf 57x83 reduced", 32'(res), 32'h000000C1);
`else
    check("gf 57x83", 32'(res), 32'h00002B79);
`endif
    check("gf 57x83 latency", 32'(lat), 32'(GF_LAT));
    release_result();

`ifdef GF_SEQ_MULT_REDUCE_EN
    run_job(8'h53, 8'hCA, 1'b1, res, lat);
    check("gf 53xCA reduced", 32'(res), 32'h00000001);
    release_result();
`endif

    run_job(8'h57, 8'h83, 1'b0, res, lat);
    check("int 57x83", 32'(res), 32'h00002C85);
    held = res;

    // Backpressure with ignored in_valid pulses
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out", 32'(out), 32'(held));
      check("bp in_ready", 32'(in_ready), 32'd0);
      a = 8'(k * 37 + 1); b = 8'(k + 9); gf_option = k[0];
      in_valid = (k % 2 == 0);
      tick();
    end
    in_valid = 1'b0;
    check("bp out hold end", 32'(out), 32'(held));
    release_result();
    check("post-hs out_valid", 32'(out_valid), 32'd0);
    check("post-hs in_ready", 32'(in_ready), 32'd1);
    check("post-hs out held", 32'(out), 32'(held));
    tick(); tick();
    check("no ghost job", 32'(out_valid), 32'd0);

    // Reset during the second MUL cycle
    a = 8'hAB; b = 8'hCD; gf_option = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out", 32'(out), 32'd0);
    run_job(8'h03, 8'h05, 1'b0, res, lat);
    check("after rst 3x5", 32'(res), 32'h0000000F);
    check("after rst latency", 32'(lat), 32'(L));
    release_result();

    // Back-to-back random jobs with out_ready held high
    out_ready = 1'b1;
    prev_edge = 0;
    prev_gf   = 1'b0;
    for (int j = 0; j < 16; j++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      gf_option = 1'($urandom_range(0, 1));
      exp = model(a, b, gf_option, poly);
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 40) begin
        tick();
        guard++;
      end
      this_edge = cyc + 1;
      tick();
      in_valid = 1'b0;
      if (j > 0)
        check($sformatf("b2b spacing %0d", j), 32'(this_edge - prev_edge),
              32'(((prev_gf) ? GF_LAT : L) + 2));
      guard = 0;
      while (!out_valid && guard < 40) begin
        tick();
        guard++;
      end
      check($sformatf("b2b result %0d", j), 32'(out), 32'(exp));
      prev_edge = this_edge;
      prev_gf   = gf_option;
    end
    out_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
